// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: serialises a parallel word LSB first, then appends a
// parity bit, then idles for GAP_CYC cycles before taking the next word.
// Optional build macro: PARITY_FRAME_ODD_EN selects odd parity for the sent
// parity bit; o_parity always reports the raw running XOR.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for a word, o_ready high
//   S_SHIFT | presenting data bit r_cnt on o_x, advancing on i_sink_ready
//   S_PAR   | presenting the parity bit, advancing on i_sink_ready
//   S_GAP   | inter-frame gap, counting down GAP_CYC cycles
module parity_frame_ctrl #(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sink_ready,
    output logic              o_x,
    output logic              o_x_valid,
    output logic              o_sof,
    output logic              o_is_par,
    output logic              o_parity,
    output logic              o_done,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    // Gap counter is loaded with GAP_CYC-1 so the gap lasts exactly GAP_CYC cycles.
    localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_gap;

    logic r_x, r_sof, r_is_par, r_parity, r_done, r_busy;
    logic w_x_nxt, w_sof_nxt, w_is_par_nxt, w_parity_nxt, w_done_nxt, w_busy_nxt;

    logic              w_accept;
    logic              w_advance;
    logic              w_last;
    logic              w_par_done;
    logic              w_par_upd;
    logic              w_par_bit;
    logic [DATA_W-1:0] w_shreg_sh;

    assign w_accept   = (r_state == S_IDLE) && i_valid;
    assign w_advance  = (r_state == S_SHIFT) && i_sink_ready;
    assign w_last     = w_advance && (r_cnt == LAST_BIT);
    assign w_par_done = (r_state == S_PAR) && i_sink_ready;
    assign w_par_upd  = r_parity ^ r_x;
    assign w_shreg_sh = r_shreg >> 1;

`ifdef PARITY_FRAME_ODD_EN
    assign w_par_bit = ~w_par_upd;
`else
    assign w_par_bit = w_par_upd;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = S_PAR;
                end
            end
            S_PAR: begin
                if (i_sink_ready) begin
                    w_state_nxt = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_x_nxt      = r_x;
        w_sof_nxt    = r_sof;
        w_is_par_nxt = r_is_par;
        w_parity_nxt = r_parity;
        w_done_nxt   = 1'b0;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_x_nxt      = i_data[0];
                    w_sof_nxt    = 1'b1;
                    w_is_par_nxt = 1'b0;
                    w_parity_nxt = 1'b0;
                end
            end
            S_SHIFT: begin
                if (i_sink_ready) begin
                    w_parity_nxt = w_par_upd;
                    w_sof_nxt    = 1'b0;
                    if (r_cnt == LAST_BIT) begin
                        w_x_nxt      = w_par_bit;
                        w_is_par_nxt = 1'b1;
                    end else begin
                        w_x_nxt = w_shreg_sh[0];
                    end
                end
            end
            S_PAR: begin
                if (i_sink_ready) begin
                    w_done_nxt   = 1'b1;
                    w_is_par_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= 1'b0;
            r_sof    <= 1'b0;
            r_is_par <= 1'b0;
            r_parity <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_sof    <= w_sof_nxt;
            r_is_par <= w_is_par_nxt;
            r_parity <= w_parity_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Shift register, bit counter and gap down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_gap   <= 4'd0;
        end else begin
            if (w_accept) begin
                r_shreg <= i_data;
                r_cnt   <= '0;
            end else if (w_advance) begin
                r_shreg <= w_shreg_sh;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_par_done) begin
                r_gap <= GAP_LOAD;
            end else if ((r_state == S_GAP) && (r_gap != 4'd0)) begin
                r_gap <= r_gap - 4'd1;
            end
        end
    end

    assign o_ready   = (r_state == S_IDLE) && !reset;
    assign o_x_valid = (r_state == S_SHIFT) || (r_state == S_PAR);
    assign o_x       = r_x;
    assign o_sof     = r_sof;
    assign o_is_par  = r_is_par;
    assign o_parity  = r_parity;
    assign o_done    = r_done;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Testbench for parity_frame_ctrl: directed frames from the test plan followed
// by randomized words, sink backpressure and occasional resets. A driver pushes
// the expected frame into a queue on each acceptance; a negedge monitor pops
// and compares whatever the DUT presents.
module tb_parity_frame_ctrl;

    localparam int DATA_W  = 8;
    localparam int GAP_CYC = 1;
    localparam int PERIOD  = DATA_W + 2 + GAP_CYC;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic              i_sink_ready;
    logic              o_x;
    logic              o_x_valid;
    logic              o_sof;
    logic              o_is_par;
    logic              o_parity;
    logic              o_done;
    logic              o_busy;

    parity_frame_ctrl #(
        .DATA_W (DATA_W),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sink_ready(i_sink_ready),
        .o_x         (o_x),
        .o_x_valid   (o_x_valid),
        .o_sof       (o_sof),
        .o_is_par    (o_is_par),
        .o_parity    (o_parity),
        .o_done      (o_done),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic x;
        logic sof;
        logic is_par;
        logic par;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected frame: data bits LSB first, o_parity = XOR of bits already sent,
    // then the parity bit making the frame's total ones even (odd in the odd build).
    task automatic push_word(input logic [DATA_W-1:0] w);
        logic run;
        exp_t e;
        run = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            e.x = w[i]; e.sof = (i == 0); e.is_par = 1'b0; e.par = run;
            q.push_back(e);
            run = run ^ w[i];
        end
`ifdef PARITY_FRAME_ODD_EN
        e.x = ~run;
`else
        e.x = run;
`endif
        e.sof = 1'b0; e.is_par = 1'b1; e.par = run;
        q.push_back(e);
    endtask

    // ---------------- driver ----------------
    logic              acc_pending = 1'b0;
    logic [DATA_W-1:0] acc_word;
    int                acc_cyc;

    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic sr, input logic rst);
        @(posedge clk);
        #1;
        if (acc_pending) begin
            push_word(acc_word);
            acc_pending = 1'b0;
        end
        i_valid = v; i_data = d; i_sink_ready = sr; reset = rst;
        #1;
        if (v && !rst && o_ready) begin
            acc_pending = 1'b1;
            acc_word    = d;
            acc_cyc     = cyc_n;
        end
    endtask

    function automatic logic rnd_sink(input logic rnd);
        return rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
    endfunction

    task automatic send(input logic [DATA_W-1:0] d, input logic rnd, output int at);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            cyc(1'b1, d, rnd_sink(rnd), 1'b0);
            got = acc_pending;
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        at = acc_cyc;
    endtask

    task automatic wait_idle(input logic rnd);
        logic idle;
        idle = 1'b0;
        for (int k = 0; k < 400 && !idle; k++) begin
            cyc(1'b0, '0, rnd_sink(rnd), 1'b0);
            idle = o_ready && (q.size() == 0) && !acc_pending;
        end
        if (!idle) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- monitor ----------------
    logic rst_seen = 1'b1;
    logic done_exp = 1'b0;
    int   gap_cnt  = 0;

    always @(negedge clk) begin
        exp_t e;
        logic idle;
        if (rst_seen) begin
            chk("rst_outputs", {25'd0, o_x, o_x_valid, o_sof, o_is_par, o_parity, o_done, o_busy}, 32'd0);
            chk("rst_ready", {31'd0, o_ready}, {31'd0, !reset});
        end else begin
            chk("done", {31'd0, o_done}, {31'd0, done_exp});
            done_exp = 1'b0;
            idle = (q.size() == 0) && (gap_cnt == 0);
            chk("ready", {31'd0, o_ready}, {31'd0, idle});
            chk("busy", {31'd0, o_busy}, {31'd0, !idle});
            chk("x_valid", {31'd0, o_x_valid}, {31'd0, q.size() != 0});
            if (gap_cnt > 0) gap_cnt--;
            if (o_x_valid && q.size() != 0) begin
                e = q[0];
                chk("x", {31'd0, o_x}, {31'd0, e.x});
                chk("sof", {31'd0, o_sof}, {31'd0, e.sof});
                chk("is_par", {31'd0, o_is_par}, {31'd0, e.is_par});
                chk("parity", {31'd0, o_parity}, {31'd0, e.par});
                if (i_sink_ready) begin
                    void'(q.pop_front());
                    if (e.is_par) begin
                        done_exp = 1'b1;
                        gap_cnt  = GAP_CYC;
                    end
                end
            end
        end
        rst_seen = reset;
        if (reset) begin
            q.delete();
            done_exp = 1'b0;
            gap_cnt  = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t1, t2, t;
        reset = 1'b1; i_valid = 1'b0; i_data = '0; i_sink_ready = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);

        // basic frame and odd-weight word
        send(8'hA5, 1'b0, t); wait_idle(1'b0);
        send(8'h07, 1'b0, t); wait_idle(1'b0);

        // backpressure while bit index 2 is presented
        send(8'h3C, 1'b0, t);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b0, 1'b0);
        wait_idle(1'b0);

        // reset during bit 4 of 8'hFF, then a clean frame
        send(8'hFF, 1'b0, t);
        for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        send(8'h01, 1'b0, t); wait_idle(1'b0);

        // back-to-back acceptance with valid held high
        send(8'h01, 1'b0, t1);
        send(8'h02, 1'b0, t2);
        chk("b2b_interval", 32'(t2 - t1), 32'(PERIOD));
        wait_idle(1'b0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int idle_n;
            idle_n = int'($urandom_range(3, 0));
            for (int k = 0; k < idle_n; k++) cyc(1'b0, DATA_W'($urandom), rnd_sink(1'b1), 1'b0);
            send(DATA_W'($urandom), 1'b1, t);
            if ($urandom_range(7, 0) == 0) begin
                int dly;
                dly = int'($urandom_range(10, 1));
                for (int k = 0; k < dly; k++) cyc(1'b0, '0, rnd_sink(1'b1), 1'b0);
                cyc(1'b0, '0, 1'b1, 1'b1);
                cyc(1'b0, '0, 1'b1, 1'b0);
            end
        end
        wait_idle(1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
